// File: rtl/pipe_scroller.sv
// Obstacle generator: scrolls one pipe leftward across a 16x16 grid, picks each
// new gap row from a 4-bit LFSR, counts pipes passed and freezes on collision.
module pipe_scroller #(
    parameter int         TICK_DIV  = 8,
    parameter int         GAP_SIZE  = 4,
    parameter int         BIRD_X    = 2,
    parameter logic [3:0] LFSR_SEED = 4'b1011
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       collision,
    output logic [3:0] pipe_x,
    output logic [3:0] gap_y,
    output logic [7:0] score,
    output logic       active,
    output logic       pipe_wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LIMIT = 4'(16 - GAP_SIZE);
    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [3:0] BIRD_COL  = 4'(BIRD_X);

    state_t     state;
    logic [3:0] lfsr;
    logic [7:0] tick;

    // Fold the LFSR value into a row range that keeps the whole gap on the grid.
    function automatic logic [3:0] clamp(input logic [3:0] v);
        return (v > GAP_LIMIT) ? v - GAP_LIMIT : v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            tick      <= 8'd0;
            pipe_x    <= 4'd15;
            gap_y     <= clamp(LFSR_SEED);
            score     <= 8'd0;
            active    <= 1'b0;
            pipe_wrap <= 1'b0;
        end else begin
            lfsr      <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            pipe_wrap <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state  <= RUN;
                        active <= 1'b1;
                        tick   <= 8'd0;
                        score  <= 8'd0;
                        pipe_x <= 4'd15;
                        gap_y  <= clamp(lfsr);
                    end
                end
                RUN: begin
                    // Collision wins over any step, score or wrap on the same edge.
                    if (collision) begin
                        state  <= OVER;
                        active <= 1'b0;
                    end else if (tick == TICK_LAST) begin
                        tick <= 8'd0;
                        if (pipe_x == 4'd0) begin
                            pipe_x    <= 4'd15;
                            gap_y     <= clamp(lfsr);
                            pipe_wrap <= 1'b1;
                        end else begin
                            pipe_x <= pipe_x - 4'd1;
                        end
                        if (pipe_x == BIRD_COL && score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: reset, scrolling, scoring, wrap, saturation,
// collision freeze, restart from OVER and asynchronous reset mid-game.
module tb_pipe_scroller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       collision;
    logic [3:0] pipe_x;
    logic [3:0] gap_y;
    logic [7:0] score;
    logic       active;
    logic       pipe_wrap;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    logic [3:0] m_lfsr;
    logic [3:0] m_prev;
    logic [3:0] saved_gap;
    logic       seen13;

    pipe_scroller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .collision (collision),
        .pipe_x    (pipe_x),
        .gap_y     (gap_y),
        .score     (score),
        .active    (active),
        .pipe_wrap (pipe_wrap)
    );

    always #5 clk = ~clk;

    // Reference LFSR; m_prev holds the value in force before the latest edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr <= 4'b1011;
            m_prev <= 4'b1011;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
        end
    end

    function automatic logic [15:0] clamp_m(input logic [3:0] v);
        return (v > 4'd12) ? 16'(v - 4'd12) : 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        ecount += n;
    endtask

    task automatic goto_edge(input int target);
        if (target > ecount) step(target - ecount);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        collision = 1'b0;
        seen13    = 1'b0;
        #21;
        chk("reset_pipe_x", 16'(pipe_x), 16'd15);
        chk("reset_gap_y", 16'(gap_y), 16'd11);
        chk("reset_score", 16'(score), 16'd0);
        chk("reset_active", 16'(active), 16'd0);
        chk("reset_wrap", 16'(pipe_wrap), 16'd0);
        #1;
        reset_n = 1'b1;

        // Start on the first edge after reset release.
        start = 1'b1;
        step(1);
        start  = 1'b0;
        ecount = 0;
        chk("start_active", 16'(active), 16'd1);
        chk("start_pipe_x", 16'(pipe_x), 16'd15);
        chk("start_gap_y", 16'(gap_y), 16'd11);
        chk("start_score", 16'(score), 16'd0);

        goto_edge(7);
        chk("edge7_pipe_x", 16'(pipe_x), 16'd15);
        goto_edge(8);
        chk("edge8_pipe_x", 16'(pipe_x), 16'd14);
        goto_edge(111);
        chk("edge111_pipe_x", 16'(pipe_x), 16'd2);
        chk("edge111_score", 16'(score), 16'd0);
        goto_edge(112);
        chk("edge112_pipe_x", 16'(pipe_x), 16'd1);
        chk("edge112_score", 16'(score), 16'd1);
        goto_edge(120);
        chk("edge120_pipe_x", 16'(pipe_x), 16'd0);
        goto_edge(127);
        chk("edge127_pipe_x", 16'(pipe_x), 16'd0);
        chk("edge127_wrap", 16'(pipe_wrap), 16'd0);
        goto_edge(128);
        chk("wrap1_pipe_x", 16'(pipe_x), 16'd15);
        chk("wrap1_pulse", 16'(pipe_wrap), 16'd1);
        chk("wrap1_gap_y", 16'(gap_y), clamp_m(m_prev));
        goto_edge(129);
        chk("wrap1_pulse_end", 16'(pipe_wrap), 16'd0);
        goto_edge(240);
        chk("pass2_score", 16'(score), 16'd2);
        chk("pass2_pipe_x", 16'(pipe_x), 16'd1);

        // Start during RUN must not disturb position, score or tick phase.
        start = 1'b1;
        step(3);
        start = 1'b0;
        goto_edge(247);
        chk("runstart_pipe_x_hold", 16'(pipe_x), 16'd1);
        chk("runstart_score", 16'(score), 16'd2);
        chk("runstart_active", 16'(active), 16'd1);
        goto_edge(248);
        chk("runstart_pipe_x_step", 16'(pipe_x), 16'd0);

        // Long run: every wrap gets a clamped gap; score saturates at 255.
        for (int k = 3; k <= 256; k++) begin
            goto_edge(128 * (k - 1));
            chk("wrap_pulse", 16'(pipe_wrap), 16'd1);
            chk("wrap_gap_y", 16'(gap_y), clamp_m(m_prev));
            chk("wrap_gap_range", 16'(gap_y >= 4'd1 && gap_y <= 4'd12), 16'd1);
            if (m_prev == 4'd13) begin
                seen13 = 1'b1;
                chk("lfsr13_gap", 16'(gap_y), 16'd1);
            end
            goto_edge(112 + 128 * (k - 1));
            chk("sat_score", 16'(score), (k > 255) ? 16'd255 : 16'(k));
            chk("sat_pipe_x", 16'(pipe_x), 16'd1);
        end
        chk("lfsr13_seen", 16'(seen13), 16'd1);

        // Collision on the edge that would step 5 -> 4.
        goto_edge(32855);
        chk("precoll_pipe_x", 16'(pipe_x), 16'd5);
        saved_gap = gap_y;
        collision = 1'b1;
        step(1);
        collision = 1'b0;
        chk("coll_pipe_x", 16'(pipe_x), 16'd5);
        chk("coll_active", 16'(active), 16'd0);
        chk("coll_score", 16'(score), 16'd255);
        for (int i = 0; i < 50; i++) begin
            collision = (i % 3 == 0);
            step(1);
            chk("over_pipe_x", 16'(pipe_x), 16'd5);
            chk("over_active", 16'(active), 16'd0);
        end
        collision = 1'b0;
        chk("over_gap_y", 16'(gap_y), 16'(saved_gap));
        chk("over_score", 16'(score), 16'd255);
        chk("over_wrap", 16'(pipe_wrap), 16'd0);

        // Restart from OVER.
        start = 1'b1;
        step(1);
        start  = 1'b0;
        ecount = 0;
        chk("restart_score", 16'(score), 16'd0);
        chk("restart_pipe_x", 16'(pipe_x), 16'd15);
        chk("restart_active", 16'(active), 16'd1);
        chk("restart_gap_y", 16'(gap_y), clamp_m(m_prev));
        goto_edge(8);
        chk("restart_edge8_pipe_x", 16'(pipe_x), 16'd14);
        goto_edge(120);
        chk("prereset_score", 16'(score), 16'd1);
        chk("prereset_pipe_x", 16'(pipe_x), 16'd0);

        // Asynchronous reset between clock edges.
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset_pipe_x", 16'(pipe_x), 16'd15);
        chk("areset_gap_y", 16'(gap_y), 16'd11);
        chk("areset_score", 16'(score), 16'd0);
        chk("areset_active", 16'(active), 16'd0);
        #2;
        reset_n = 1'b1;
        step(30);
        chk("idle_active", 16'(active), 16'd0);
        chk("idle_pipe_x", 16'(pipe_x), 16'd15);
        chk("idle_score", 16'(score), 16'd0);
        chk("idle_gap_y", 16'(gap_y), 16'd11);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("final_active", 16'(active), 16'd1);
        chk("final_gap_y", 16'(gap_y), clamp_m(m_prev));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Obstacle generator directly upstream of the collision detector.
- Produces the 4-bit pipe column and gap row on a 16x16 grid, scrolls the pipe leftward at a fixed tick rate, and randomises each new gap with a 4-bit LFSR.
- Counts pipes passed by the bird and freezes play when the collision input fires.

Parameters:
- TICK_DIV, 8, clock cycles per one-column pipe step (2..255)
- GAP_SIZE, 4, gap height in rows; must match the collision detector
- BIRD_X, 2, fixed bird column used for scoring (1..15)
- LFSR_SEED, 4'b1011, LFSR reset value; must be nonzero

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  level; begins or restarts a game
- collision  input  1  from the collision detector; game over request
- pipe_x  output  4  current pipe column
- gap_y  output  4  top row of the current gap
- score  output  8  pipes passed, saturating
- active  output  1  high while in RUN
- pipe_wrap  output  1  one-cycle pulse when a new pipe spawns at column 15

Behaviour:
- Reset, asynchronous, active immediately and mid-operation: state=IDLE, pipe_x=15, gap_y=clamp(LFSR_SEED), score=0, active=0, pipe_wrap=0, tick counter=0, lfsr=LFSR_SEED.
- LFSR:
  - Fibonacci, next = {lfsr[2:0], lfsr[3]^lfsr[2]}.
  - Advances every clock in every state; never reaches 0.
- clamp(v): if v > 16-GAP_SIZE then v-(16-GAP_SIZE), else v. Default range is 1..12, so gap_y+GAP_SIZE <= 16.
- Game start (IDLE -> RUN, or OVER -> RUN), on any edge with start=1:
  - Next state RUN, active=1, tick counter=0, score=0, pipe_x=15.
  - gap_y = clamp(lfsr value before this edge).
- IDLE: all outputs held at their current values.
- RUN, tick counter:
  - Counts 0..TICK_DIV-1.
  - At the edge where it equals TICK_DIV-1, it returns to 0 and a step occurs.
- RUN, step:
  - If pipe_x==0: pipe_x=15, gap_y=clamp(lfsr before the edge), pipe_wrap=1 for exactly the following cycle.
  - Otherwise pipe_x decrements by 1.
- RUN, scoring:
  - score increments by 1 on the step that moves pipe_x from BIRD_X to BIRD_X-1.
  - Saturates at 255.
- First step timing: pipe_x changes 15 -> 14 on the TICK_DIV-th rising edge after the start edge.
- RUN, collision:
  - collision=1 at an edge sends the next state to OVER with active=0.
  - This takes priority over a step, scoring and a wrap on that same edge: pipe_x, gap_y and score are not updated.
- RUN, start: ignored.
- OVER:
  - pipe_x, gap_y and score are frozen, active=0, pipe_wrap=0.
  - collision is ignored.
  - start=1 restarts the game as described under Game start.
- pipe_wrap is 0 on every cycle except the one following a wrap step.
- All outputs are registered. The single state machine uses the states IDLE, RUN and OVER.

Test Plan:
- Reset, then start=1 at the first edge -> active=1, pipe_x=15, gap_y=11 (seed 1011); pipe_x=14 exactly 8 edges later; pipe_x=0 at edge 120; pipe_x=15 with pipe_wrap=1 for one cycle at edge 128.
- Let the game run with no collision -> score goes 0->1 on the edge where pipe_x goes 2->1 (edge 112); score=2 after a second pass; force a long run to check saturation at 255 with no wrap to 0.
- In RUN, assert collision for one cycle on a step edge (pipe_x=5) -> pipe_x stays 5, state OVER, active=0; values stay frozen for 50 cycles despite further collision pulses.
- In OVER, assert start -> score=0, pipe_x=15, active=1; gap_y equals clamp of the LFSR value; over 20 wraps every gap_y lies in 1..12, and an LFSR value of 13 maps to 1.
- Deassert reset_n asynchronously mid-RUN (between clock edges) -> outputs return to their reset values immediately; the block stays in IDLE until start.
- Assert start while in RUN -> no effect on pipe_x, score or the tick phase.
